// File: rtl/riscv_prefetch_ctrl.sv
// riscv_prefetch_ctrl: IF-stage prefetcher issuing word fetches over req/gnt/rvalid
// into a DEPTH-entry FIFO; ports: clk/rst_n, req/branch control, instr_* bus, fetch_* aligner side.
module riscv_prefetch_ctrl #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_rdata_o,
  input  logic        fetch_ready_i,
  input  logic        raw_instr_hold_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = '0;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW:0]   CAP  = (CW+1)'(DEPTH);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [31:0]   BOOT = BOOT_ADDR & ~32'h3;

  typedef enum logic [1:0] {IDLE, REQ, FLUSH_WAIT} state_t;

  state_t        state;
  logic [31:0]   fetch_addr;
  logic [31:0]   tgt_addr;
  logic [31:0]   br_tgt;
  logic [CW-1:0] out_cnt, disc_cnt, fifo_cnt;
  logic [CW-1:0] out_nxt, disc_nxt, fifo_nxt;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   buf_q [DEPTH];
  logic          gnt_fire, push, pop;
  logic          sp_now, sp_next;

  assign br_tgt   = branch_addr_i & ~32'h3;
  assign gnt_fire = instr_req_o & instr_gnt_i;
  assign push     = instr_rvalid_i & (disc_cnt == ZERO) & ~branch_i;
  assign pop      = fetch_valid_o & fetch_ready_i
                  & ~raw_instr_hold_i & ~branch_i;

  assign instr_addr_o  = fetch_addr;
  assign fetch_valid_o = (fifo_cnt != ZERO);
  assign fetch_rdata_o = fetch_valid_o ? buf_q[rd_ptr] : '0;

  always_comb begin
    out_nxt  = out_cnt + (gnt_fire ? ONE : ZERO)
             - (instr_rvalid_i ? ONE : ZERO);
    disc_nxt = disc_cnt;
    fifo_nxt = ZERO;
    if (branch_i) begin
      disc_nxt = out_nxt;
    end else begin
      if (instr_rvalid_i && disc_cnt != ZERO)
        disc_nxt = disc_nxt - ONE;
      // the request held through a flush is stale once granted
      if (state == FLUSH_WAIT && gnt_fire)
        disc_nxt = disc_nxt + ONE;
      fifo_nxt = fifo_cnt + (push ? ONE : ZERO)
               - (pop ? ONE : ZERO);
    end
  end

  assign sp_now  = ({1'b0, fifo_cnt} + {1'b0, out_cnt}) < CAP;
  assign sp_next = ({1'b0, fifo_nxt} + {1'b0, out_nxt}) < CAP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      instr_req_o <= 1'b0;
      fetch_addr  <= BOOT;
      tgt_addr    <= BOOT;
      out_cnt     <= ZERO;
      disc_cnt    <= ZERO;
      fifo_cnt    <= ZERO;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      out_cnt  <= out_nxt;
      disc_cnt <= disc_nxt;
      fifo_cnt <= fifo_nxt;
      if (branch_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PONE;
        if (pop)  rd_ptr <= rd_ptr + PONE;
      end
      unique case (state)
        IDLE: begin
          if (branch_i) fetch_addr <= br_tgt;
          if (req_i && (branch_i ? sp_next : sp_now)) begin
            state       <= REQ;
            instr_req_o <= 1'b1;
          end
        end
        REQ: begin
          if (branch_i && !instr_gnt_i) begin
            // bus request cannot be retracted; park the target
            state    <= FLUSH_WAIT;
            tgt_addr <= br_tgt;
          end else if (branch_i || instr_gnt_i) begin
            fetch_addr <= branch_i ? br_tgt : fetch_addr + 32'd4;
            if (!(req_i && sp_next)) begin
              state       <= IDLE;
              instr_req_o <= 1'b0;
            end
          end
        end
        FLUSH_WAIT: begin
          if (branch_i) tgt_addr <= br_tgt;
          if (instr_gnt_i) begin
            fetch_addr <= branch_i ? br_tgt : tgt_addr;
            if (req_i && sp_next) begin
              state <= REQ;
            end else begin
              state       <= IDLE;
              instr_req_o <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          instr_req_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr] <= instr_rdata_i;
  end

  a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_cnt == FULL));
  a_no_unf: assert property (@(posedge clk) disable iff (!rst_n)
    !(instr_rvalid_i && out_cnt == ZERO));

endmodule

// File: tb/tb_riscv_prefetch_ctrl.sv
// tb_riscv_prefetch_ctrl: vector table, directed corner sequences and a
// randomized run checked against an in-order memory and word-stream model.
module tb_riscv_prefetch_ctrl;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BOOT  = 32'h0000_0082;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i, branch_i;
  logic [31:0] branch_addr_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_rdata_o;
  logic        fetch_ready_i, raw_instr_hold_i;

  always #5 clk = ~clk;

  riscv_prefetch_ctrl #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i),
    .fetch_valid_o(fetch_valid_o), .fetch_rdata_o(fetch_rdata_o),
    .fetch_ready_i(fetch_ready_i), .raw_instr_hold_i(raw_instr_hold_i)
  );

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ (a << 3) ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_dat;
  } vec_t;
  vec_t tv [10];

  // memory / scoreboard state
  logic [31:0] q[$];
  logic [31:0] exp_addr;
  logic [31:0] stab_addr;
  logic        stab_chk, flush_chk;
  int          ngnt;
  logic        k_req, k_gnt, k_rv, k_ready, k_hold, k_br;
  logic [31:0] k_baddr;

  task automatic drive_idle();
    req_i = 0; branch_i = 0; branch_addr_i = 0;
    instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0;
    fetch_ready_i = 0; raw_instr_hold_i = 0;
  endtask

  task automatic sb_clear();
    q.delete();
    exp_addr = 32'h80;
    stab_chk = 0; flush_chk = 0; ngnt = 0;
    k_req = 0; k_gnt = 0; k_rv = 0; k_ready = 0; k_hold = 0;
    k_br = 0; k_baddr = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 0;
    sb_clear();
    @(negedge clk);
    rst_n = 1;
  endtask

  // one bus cycle: drive at negedge, score what the next edge will do
  task automatic cycle();
    logic rv, pop, fire;
    rv = k_rv && (q.size() > 0);
    req_i = k_req; instr_gnt_i = k_gnt; instr_rvalid_i = rv;
    instr_rdata_i = $urandom;
    if (rv) instr_rdata_i = memf(q[0]);
    branch_i = k_br; branch_addr_i = k_baddr;
    fetch_ready_i = k_ready; raw_instr_hold_i = k_hold;
    if (flush_chk) begin
      chk("flush_empty", {31'b0, fetch_valid_o}, 32'd0);
      flush_chk = 0;
    end
    if (stab_chk) begin
      chk("nogrant_req", {31'b0, instr_req_o}, 32'd1);
      chk("nogrant_addr", instr_addr_o, stab_addr);
    end
    pop = fetch_valid_o && k_ready && !k_hold && !k_br;
    if (pop) begin
      chk("pop_data", fetch_rdata_o, memf(exp_addr));
      exp_addr += 32'd4;
    end
    if (k_br) begin
      exp_addr = k_baddr & ~32'h3;
      flush_chk = 1;
    end
    stab_chk = instr_req_o && !k_gnt;
    stab_addr = instr_addr_o;
    fire = instr_req_o && k_gnt;
    if (rv) void'(q.pop_front());
    if (fire) begin
      q.push_back(instr_addr_o);
      ngnt++;
      chk("outstanding_cap", {31'b0, q.size() <= DEPTH}, 32'd1);
    end
    @(negedge clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a_old;
    logic        found;
    tv[0] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h80, 1'b0, 32'h0};
    tv[1] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h80, 1'b0, 32'h0};
    tv[2] = '{1'b1, 1'b1, memf(32'h80), 1'b1, 32'h84, 1'b0, 32'h0};
    tv[3] = '{1'b1, 1'b1, memf(32'h84), 1'b1, 32'h88, 1'b1, memf(32'h80)};
    tv[4] = '{1'b1, 1'b1, memf(32'h88), 1'b1, 32'h8C, 1'b1, memf(32'h84)};
    tv[5] = '{1'b1, 1'b1, memf(32'h8C), 1'b1, 32'h90, 1'b1, memf(32'h88)};
    tv[6] = '{1'b0, 1'b1, memf(32'h90), 1'b1, 32'h94, 1'b1, memf(32'h8C)};
    tv[7] = '{1'b0, 1'b1, memf(32'h94), 1'b0, 32'h98, 1'b1, memf(32'h90)};
    tv[8] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h98, 1'b1, memf(32'h94)};
    tv[9] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h98, 1'b0, 32'h0};

    drive_idle();
    sb_clear();
    repeat (3) @(negedge clk);
    rst_n = 1;

    // streaming from boot, gnt high, rvalid one cycle later
    for (int i = 0; i < 10; i++) begin
      req_i = tv[i].req; instr_gnt_i = 1'b1;
      instr_rvalid_i = tv[i].rv; instr_rdata_i = tv[i].rd;
      fetch_ready_i = 1'b1; raw_instr_hold_i = 1'b0; branch_i = 1'b0;
      chk($sformatf("tv%0d_req", i), {31'b0, instr_req_o}, {31'b0, tv[i].e_req});
      chk($sformatf("tv%0d_addr", i), instr_addr_o, tv[i].e_addr);
      chk($sformatf("tv%0d_valid", i), {31'b0, fetch_valid_o}, {31'b0, tv[i].e_val});
      chk($sformatf("tv%0d_rdata", i), fetch_rdata_o, tv[i].e_dat);
      @(negedge clk);
    end

    do_reset();

    // stalled consumer: exactly DEPTH grants, one pop frees one request
    k_req = 1; k_gnt = 1; k_rv = 1; k_ready = 0;
    repeat (12) cycle();
    chk("stall_grants", ngnt, 32'd4);
    chk("stall_req_low", {31'b0, instr_req_o}, 32'd0);
    k_ready = 1;
    cycle();
    k_ready = 0;
    repeat (10) cycle();
    chk("one_pop_grants", ngnt, 32'd5);
    chk("one_pop_req_low", {31'b0, instr_req_o}, 32'd0);

    // hold keeps the head for two cycles, pop on the first hold=0
    k_ready = 1; k_hold = 1;
    repeat (2) begin
      chk("hold_valid", {31'b0, fetch_valid_o}, 32'd1);
      chk("hold_head", fetch_rdata_o, memf(exp_addr));
      cycle();
    end
    k_hold = 0;
    chk("hold_head_last", fetch_rdata_o, memf(exp_addr));
    cycle();
    k_ready = 0;
    chk("after_hold_head", fetch_rdata_o, memf(exp_addr));
    chk("after_hold_valid", {31'b0, fetch_valid_o}, 32'd1);

    k_req = 0; k_ready = 1;
    repeat (12) cycle();

    // branch to 0x1006 with two requests outstanding
    k_req = 1; k_gnt = 1; k_rv = 0; k_ready = 1;
    cycle();
    cycle();
    k_req = 0;
    cycle();
    chk("br_outstanding", q.size(), 32'd2);
    chk("br_pre_req", {31'b0, instr_req_o}, 32'd0);
    k_req = 1; k_br = 1; k_baddr = 32'h1006;
    cycle();
    k_br = 0; k_rv = 1;
    chk("br_addr", instr_addr_o, 32'h1004);
    chk("br_req", {31'b0, instr_req_o}, 32'd1);
    repeat (10) cycle();
    chk("br_progress", {31'b0, exp_addr > 32'h1004}, 32'd1);

    // branch while the request waits for a grant
    repeat (6) cycle();
    chk("fw_pre_req", {31'b0, instr_req_o}, 32'd1);
    a_old = instr_addr_o;
    k_gnt = 0; k_br = 1; k_baddr = 32'h2000;
    cycle();
    k_br = 0;
    repeat (2) begin
      chk("fw_addr_held", instr_addr_o, a_old);
      chk("fw_req_held", {31'b0, instr_req_o}, 32'd1);
      cycle();
    end
    k_gnt = 1;
    chk("fw_addr_grant", instr_addr_o, a_old);
    cycle();
    chk("fw_target_addr", instr_addr_o, 32'h2000);
    chk("fw_target_req", {31'b0, instr_req_o}, 32'd1);
    repeat (10) cycle();
    chk("fw_progress", {31'b0, exp_addr > 32'h2000}, 32'd1);

    // branch coinciding with an arriving response and a pop
    found = 0;
    for (int w = 0; w < 20 && !found; w++) begin
      if (fetch_valid_o && q.size() > 0) found = 1;
      else cycle();
    end
    chk("brpop_setup", {31'b0, found}, 32'd1);
    if (found) begin
      k_br = 1; k_baddr = 32'h3000;
      cycle();
      k_br = 0;
      chk("brpop_empty", {31'b0, fetch_valid_o}, 32'd0);
      repeat (10) cycle();
      chk("brpop_progress", {31'b0, exp_addr > 32'h3000}, 32'd1);
    end

    // asynchronous reset in the middle of streaming
    #2;
    rst_n = 0;
    #1;
    chk("arst_req", {31'b0, instr_req_o}, 32'd0);
    chk("arst_addr", instr_addr_o, 32'h80);
    chk("arst_valid", {31'b0, fetch_valid_o}, 32'd0);
    chk("arst_rdata", fetch_rdata_o, 32'd0);
    @(negedge clk);
    do_reset();

    // randomized traffic against the stream model
    for (int n = 0; n < 4000; n++) begin
      k_req   = ($urandom_range(0, 9) < 8);
      k_gnt   = ($urandom_range(0, 9) < 6);
      k_rv    = ($urandom_range(0, 9) < 6);
      k_ready = ($urandom_range(0, 9) < 7);
      k_hold  = ($urandom_range(0, 9) < 2);
      k_br    = ($urandom_range(0, 29) == 0);
      k_baddr = $urandom;
      cycle();
    end
    k_br = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
